reaction_timer_system: RTL and testbench

Reaction-time benchmark for a 4-digit multiplexed seven-segment display. A start pulse arms a pseudo-random wait. After the wait, `react` is raised and elapsed milliseconds are counted until the user presses. The result (0000–9999 ms, BCD) is shown by scanning one digit at a time. The block integrates a 16-bit LCG random source, the benchmark FSM/counter, and the segment decoder, and sits directly behind board buttons and the display pins.

---
 rtl/reaction_timer_system.sv | 165 ++++++++++++++++
 tb/tb_reaction_timer_system.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_timer_system.sv
`default_nettype none
// reaction_timer_system: LCG-randomised reaction-time benchmark with a 4-digit BCD
// result scanned onto a multiplexed seven-segment display. Rev 1.0
module reaction_timer_system #(
  parameter int CLKS_PER_MS  = 50,
  parameter int MIN_DELAY_MS = 200,
  parameter int REFRESH_CLKS = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_trigger,
  input  logic        user_trigger,
  output logic        react,
  output logic [3:0]  ms,
  output logic [1:0]  display_select,
  output logic [6:0]  segments,
  output logic [3:0]  digit_select,
  output logic [15:0] random_number
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    REACT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state, state_next;
  logic        start_prev, user_prev;
  logic        start_edge, user_edge;
  logic        load_start, false_start;
  logic        wait_done, ms_tick, refresh_wrap;
  logic        carry;
  logic [15:0] delay_ms;
  logic [31:0] delay_clks;
  logic [31:0] wait_cnt, ms_presc, refresh_cnt;
  logic [15:0] result, result_next, shown;

  assign start_edge   = start_trigger & ~start_prev;
  assign user_edge    = user_trigger & ~user_prev;
  assign delay_clks   = 32'(delay_ms) * 32'(CLKS_PER_MS);
  assign wait_done    = (wait_cnt == delay_clks - 32'd1);
  assign ms_tick      = (ms_presc == 32'(CLKS_PER_MS - 1));
  assign refresh_wrap = (refresh_cnt == 32'(REFRESH_CLKS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // User edge outranks start edge in WAIT/REACT; the reverse holds in IDLE/DONE
  // because only the start edge is decoded there.
  always_comb begin
    state_next  = state;
    load_start  = 1'b0;
    false_start = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start_edge) begin
          state_next = WAIT;
          load_start = 1'b1;
        end
      end
      WAIT: begin
        if (user_edge) begin
          state_next  = DONE;
          false_start = 1'b1;
        end else if (wait_done) begin
          state_next = REACT;
        end
      end
      REACT: begin
        if (user_edge) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Saturating 4-digit BCD increment.
  always_comb begin
    result_next = result;
    carry       = 1'b1;
    if (result != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (result[4*i +: 4] == 4'd9) begin
            result_next[4*i +: 4] = 4'd0;
          end else begin
            result_next[4*i +: 4] = result[4*i +: 4] + 4'd1;
            carry                 = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_prev    <= 1'b0;
      user_prev     <= 1'b0;
      random_number <= 16'd1;
      delay_ms      <= 16'd0;
      wait_cnt      <= 32'd0;
      ms_presc      <= 32'd0;
      result        <= 16'h0000;
    end else begin
      start_prev    <= start_trigger;
      user_prev     <= user_trigger;
      random_number <= random_number * 16'd25173 + 16'd13849;
      if (load_start) begin
        delay_ms <= 16'(MIN_DELAY_MS) + {6'd0, random_number[9:0]};
        wait_cnt <= 32'd0;
        ms_presc <= 32'd0;
        result   <= 16'h0000;
      end else if (false_start) begin
        result <= 16'h9999;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + 32'd1;
      end else if (state == REACT && !user_edge) begin
        if (ms_tick) begin
          ms_presc <= 32'd0;
          result   <= result_next;
        end else begin
          ms_presc <= ms_presc + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt    <= 32'd0;
      display_select <= 2'd0;
    end else if (refresh_wrap) begin
      refresh_cnt    <= 32'd0;
      display_select <= display_select + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 32'd1;
    end
  end

  assign react        = (state == REACT);
  assign shown        = (state == REACT || state == DONE) ? result : 16'h0000;
  assign ms           = shown[{display_select, 2'b00} +: 4];
  assign digit_select = 4'b0001 << display_select;

  always_comb begin
    segments = 7'h00;
    case (ms)
      4'd0:    segments = 7'h3F;
      4'd1:    segments = 7'h06;
      4'd2:    segments = 7'h5B;
      4'd3:    segments = 7'h4F;
      4'd4:    segments = 7'h66;
      4'd5:    segments = 7'h6D;
      4'd6:    segments = 7'h7D;
      4'd7:    segments = 7'h07;
      4'd8:    segments = 7'h7F;
      4'd9:    segments = 7'h6F;
      default: segments = 7'h00;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_reaction_timer_system.sv
`default_nettype none
// Directed testbench for reaction_timer_system using a queue-based scoreboard.
module tb_reaction_timer_system;

  localparam int CPM   = 3;
  localparam int MIN_D = 20;
  localparam int RF    = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_trigger = 1'b0;
  logic        user_trigger  = 1'b0;
  logic        react;
  logic [3:0]  ms;
  logic [1:0]  display_select;
  logic [6:0]  segments;
  logic [3:0]  digit_select;
  logic [15:0] random_number;

  reaction_timer_system #(
    .CLKS_PER_MS (CPM),
    .MIN_DELAY_MS(MIN_D),
    .REFRESH_CLKS(RF)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_trigger (start_trigger),
    .user_trigger  (user_trigger),
    .react         (react),
    .ms            (ms),
    .display_select(display_select),
    .segments      (segments),
    .digit_select  (digit_select),
    .random_number (random_number)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } item_t;

  item_t sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  // Reference models: LCG sequence and display scan phase.
  logic [15:0] m_x;
  int          m_rc;
  logic [1:0]  m_ds;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_x  <= 16'd1;
      m_rc <= 0;
      m_ds <= 2'd0;
    end else begin
      m_x <= m_x * 16'd25173 + 16'd13849;
      if (m_rc == RF - 1) begin
        m_rc <= 0;
        m_ds <= m_ds + 2'd1;
      end else begin
        m_rc <= m_rc + 1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] exp);
    item_t it;
    it.tag = tag;
    it.exp = exp;
    sb.push_back(it);
  endtask

  task automatic check(input logic [31:0] obs);
    item_t it;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $error("FAIL sb_empty: observed %0h with no expectation queued", obs);
    end else begin
      it = sb.pop_front();
      assert (obs === it.exp) else begin
        n_bad++;
        $error("FAIL %s: observed %0h expected %0h", it.tag, obs, it.exp);
      end
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic check_display(input int v, input string tag);
    logic [15:0] exp_bcd, bcd;
    logic [27:0] exp_segs, segs;
    logic        ok;
    exp_bcd  = to_bcd(v);
    exp_segs = '0;
    for (int k = 0; k < 4; k++) exp_segs[7*k +: 7] = seg_of(exp_bcd[4*k +: 4]);
    push({tag, "_digits"}, {16'd0, exp_bcd});
    push({tag, "_segs"}, {4'd0, exp_segs});
    push({tag, "_scan"}, 32'd1);
    bcd  = '0;
    segs = '0;
    ok   = 1'b1;
    for (int i = 0; i < 4 * RF; i++) begin
      bcd[4*m_ds +: 4]  = ms;
      segs[7*m_ds +: 7] = segments;
      if (display_select !== m_ds || digit_select !== (4'b0001 << m_ds)) ok = 1'b0;
      tick(1);
    end
    check({16'd0, bcd});
    check({4'd0, segs});
    check({31'd0, ok});
  endtask

  // Drives a start pulse and checks react rises exactly d clocks after the edge clock.
  task automatic start_and_wait(input int width, output int d);
    start_trigger = 1'b1;
    d = (MIN_D + int'(m_x[9:0])) * CPM;
    push("react_before_delay", 32'd0);
    push("react_at_delay", 32'd1);
    tick(width);
    start_trigger = 1'b0;
    tick(d - width);
    check({31'd0, react});
    tick(1);
    check({31'd0, react});
  endtask

  task automatic press(input int p);
    tick(p);
    user_trigger = 1'b1;
    push("react_after_press", 32'd0);
    tick(1);
    check({31'd0, react});
    user_trigger = 1'b0;
  endtask

  initial begin
    int d;
    logic never;

    // Reset state
    tick(2);
    push("rst_react", 32'd0);
    push("rst_rand", 32'd1);
    push("rst_seg", 32'h3F);
    push("rst_dsel", 32'd1);
    push("rst_disp", 32'd0);
    check({31'd0, react});
    check({16'd0, random_number});
    check({25'd0, segments});
    check({28'd0, digit_select});
    check({30'd0, display_select});

    rst = 1'b0;
    push("lcg_0", 32'd1);
    push("lcg_1", 32'd39022);
    push("lcg_2", 32'd61087);
    check({16'd0, random_number});
    tick(1);
    check({16'd0, random_number});
    tick(1);
    check({16'd0, random_number});
    tick(1);
    push("lcg_3", {16'd0, m_x});
    check({16'd0, random_number});
    check_display(0, "idle");

    // First run: press lands in the same cycle as a ms tick (discarded)
    start_and_wait(10, d);
    press(3 * 123 + 2);
    check_display(123, "run1");

    // Second run: press on an exact ms boundary
    tick(100);
    start_and_wait(1, d);
    press(3 * 456);
    check_display(456, "run2");

    // False start during WAIT
    start_trigger = 1'b1;
    d = (MIN_D + int'(m_x[9:0])) * CPM;
    tick(1);
    start_trigger = 1'b0;
    tick(5);
    user_trigger = 1'b1;
    never = 1'b1;
    for (int i = 0; i < d + 5; i++) begin
      tick(1);
      if (react !== 1'b0) never = 1'b0;
      if (i == 2) user_trigger = 1'b0;
    end
    push("false_start_no_react", 32'd1);
    check({31'd0, never});
    check_display(9999, "false_start");

    start_and_wait(2, d);
    press(50);
    check_display(16, "restart");

    // Saturation at 9999
    start_and_wait(3, d);
    tick(CPM * 10000 + 20);
    check_display(9999, "saturate");
    press(0);
    check_display(9999, "saturate_press");

    // Async reset during REACT with user trigger held through release
    start_and_wait(1, d);
    tick(40);
    user_trigger = 1'b1;
    rst = 1'b1;
    #1;
    push("arst_react", 32'd0);
    push("arst_dsel", 32'd0);
    push("arst_ms", 32'd0);
    push("arst_seg", 32'h3F);
    push("arst_digit", 32'd1);
    push("arst_rand", 32'd1);
    check({31'd0, react});
    check({30'd0, display_select});
    check({28'd0, ms});
    check({25'd0, segments});
    check({28'd0, digit_select});
    check({16'd0, random_number});
    tick(2);
    rst = 1'b0;
    tick(20);
    push("held_user_idle", 32'd0);
    check({31'd0, react});
    check_display(0, "after_reset");
    start_and_wait(4, d);
    user_trigger = 1'b0;
    press(32);
    check_display(10, "held_release");

    n_cmp++;
    assert (sb.size() === 0) else begin
      n_bad++;
      $error("FAIL sb_drain: observed %0d leftover expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
